rdm_harq_combine: RTL and testbench

Downstream neighbour of the rate-dematching read FSM. It requests rate-dematched data, then accepts 16 LLRs (6-bit) per valid beat. It maps each beat onto the circular-buffer word address (wrapping at Ncb) and soft-combines it into the HARQ combine RAM using read-modify-write with saturation. It reports completion to the Combine controller.

---
 rtl/rdm_pkg.sv | 25 ++
 rtl/rdm_llr_sat_add.sv | 40 ++++
 rtl/rdm_harq_combine.sv | 202 ++++++++++++++++++++
 tb/tb_rdm_harq_combine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdm_pkg.sv
`default_nettype none
// ============================================================================
// rdm_pkg : shared widths, saturation limits and FSM encoding for HARQ combine
// Rev 1.0
// ============================================================================
package rdm_pkg;

   localparam int LLR_W  = 6;
   localparam int LANES  = 16;
   localparam int ADDR_W = 12;
   localparam int WORD_W = LANES * LLR_W;

   localparam logic signed [LLR_W-1:0] SAT_MAX = 6'sd31;
   localparam logic signed [LLR_W-1:0] SAT_MIN = -6'sd31;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_REQ   = 5'b00010,
      ST_RUN   = 5'b00100,
      ST_FLUSH = 5'b01000,
      ST_DONE  = 5'b10000
   } state_t;

endpackage
`default_nettype wire

// File: rtl/rdm_llr_sat_add.sv
`default_nettype none
// ============================================================================
// rdm_llr_sat_add : one-lane LLR add / overwrite, symmetric saturation, mask
// Rev 1.0
// ============================================================================
module rdm_llr_sat_add
   import rdm_pkg::*;
(
   input  logic [LLR_W-1:0] i_rd_llr,
   input  logic [LLR_W-1:0] i_new_llr,
   input  logic             i_overwrite,
   input  logic             i_lane_en,
   output logic [LLR_W-1:0] o_llr
);

   localparam logic signed [LLR_W:0] c_max = {SAT_MAX[LLR_W-1], SAT_MAX};
   localparam logic signed [LLR_W:0] c_min = {SAT_MIN[LLR_W-1], SAT_MIN};

   logic signed [LLR_W:0] w_sum;

   always_comb begin
      w_sum = {i_new_llr[LLR_W-1], i_new_llr};
      if (!i_overwrite) begin
         w_sum = {i_rd_llr[LLR_W-1], i_rd_llr} + {i_new_llr[LLR_W-1], i_new_llr};
      end

      // Overwrite also clamps, so a raw -32 never reaches the RAM.
      if (!i_lane_en) begin
         o_llr = '0;
      end else if (w_sum > c_max) begin
         o_llr = SAT_MAX;
      end else if (w_sum < c_min) begin
         o_llr = SAT_MIN;
      end else begin
         o_llr = w_sum[LLR_W-1:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/rdm_harq_combine.sv
`default_nettype none
// ============================================================================
// rdm_harq_combine : maps rate-dematched beats onto the circular buffer and
// soft-combines them into the HARQ RAM (read-modify-write, 2-cycle latency)
// Rev 1.0
// ============================================================================
module rdm_harq_combine
   import rdm_pkg::*;
(
   input  logic              i_core_clk,
   input  logic              i_rx_rstn,
   input  logic              i_combine_start,
   input  logic              i_first_tx,
   input  logic [15:0]       i_ncb_size,
   input  logic [11:0]       i_word_total,
   output logic              o_rdm_data_request,
   input  logic              i_rdm_data_valid,
   input  logic [WORD_W-1:0] i_rdm_data,
   input  logic              i_rdm_data_comp,
   output logic [ADDR_W-1:0] o_ram_rd_addr,
   output logic              o_ram_rd_en,
   input  logic [WORD_W-1:0] i_ram_rd_data,
   output logic              o_ram_wr_en,
   output logic [ADDR_W-1:0] o_ram_wr_addr,
   output logic [WORD_W-1:0] o_ram_wr_data,
   output logic              o_combine_done,
   output logic              o_combine_err
);

   state_t r_state;
   state_t w_next_state;

   logic              r_first_tx;
   logic [11:0]       r_word_total;
   logic [ADDR_W-1:0] r_last_addr;
   logic [3:0]        r_last_lanes;
   logic [ADDR_W-1:0] r_ptr;
   logic [11:0]       r_beat_cnt;
   logic              r_wrapped;
   logic              r_flush_cnt;
   logic              r_err;

   logic              r_s1_vld;
   logic [ADDR_W-1:0] r_s1_addr;
   logic [WORD_W-1:0] r_s1_data;
   logic [LANES-1:0]  r_s1_lane_en;
   logic              r_s1_ovr;

   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [WORD_W-1:0] r_wr_data;

   logic              w_start;
   logic              w_accepting;
   logic              w_accept;
   logic              w_last_beat;
   logic              w_overwrite;
   logic              w_early_comp;
   logic [LANES-1:0]  w_lane_en;
   logic [WORD_W-1:0] w_comb_data;

   assign w_start      = (r_state == ST_IDLE) && i_combine_start;
   assign w_accepting  = (r_state == ST_REQ) || (r_state == ST_RUN);
   assign w_accept     = w_accepting && i_rdm_data_valid;
   assign w_last_beat  = (r_beat_cnt + 12'd1) == r_word_total;
   // First transmission overwrites only until the pointer has wrapped once.
   assign w_overwrite  = r_first_tx && !r_wrapped;
   assign w_early_comp = w_accepting && i_rdm_data_comp && !(w_accept && w_last_beat);

   always_comb begin
      w_lane_en = '1;
      for (int k = 0; k < LANES; k++) begin
         if ((r_ptr == r_last_addr) && (r_last_lanes != 4'd0) && (4'(k) >= r_last_lanes)) begin
            w_lane_en[k] = 1'b0;
         end
      end
   end

   always_ff @(posedge i_core_clk) begin
      if (!i_rx_rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_combine_start) begin
               w_next_state = ST_REQ;
            end
         end
         ST_REQ, ST_RUN: begin
            if (w_accept && w_last_beat) begin
               w_next_state = ST_FLUSH;
            end else if (i_rdm_data_comp) begin
               w_next_state = ST_FLUSH;
            end else if (w_accept) begin
               w_next_state = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (r_flush_cnt) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_core_clk) begin
      if (!i_rx_rstn) begin
         r_first_tx   <= 1'b0;
         r_word_total <= '0;
         r_last_addr  <= '0;
         r_last_lanes <= '0;
         r_ptr        <= '0;
         r_beat_cnt   <= '0;
         r_wrapped    <= 1'b0;
         r_flush_cnt  <= 1'b0;
         r_err        <= 1'b0;
         r_s1_vld     <= 1'b0;
         r_s1_addr    <= '0;
         r_s1_data    <= '0;
         r_s1_lane_en <= '0;
         r_s1_ovr     <= 1'b0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
      end else begin
         if (w_start) begin
            r_first_tx   <= i_first_tx;
            r_word_total <= i_word_total;
            r_last_addr  <= i_ncb_size[15:4] - ADDR_W'(i_ncb_size[3:0] == 4'd0);
            r_last_lanes <= i_ncb_size[3:0];
            r_ptr        <= '0;
            r_beat_cnt   <= '0;
            r_wrapped    <= 1'b0;
            r_err        <= 1'b0;
         end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 12'd1;
            if (r_ptr == r_last_addr) begin
               r_ptr     <= '0;
               r_wrapped <= 1'b1;
            end else begin
               r_ptr <= r_ptr + ADDR_W'(1);
            end
         end

         if (w_early_comp) begin
            r_err <= 1'b1;
         end

         r_flush_cnt <= (r_state == ST_FLUSH) ? !r_flush_cnt : 1'b0;

         r_s1_vld <= w_accept;
         if (w_accept) begin
            r_s1_addr    <= r_ptr;
            r_s1_data    <= i_rdm_data;
            r_s1_lane_en <= w_lane_en;
            r_s1_ovr     <= w_overwrite;
         end

         r_wr_en <= r_s1_vld;
         if (r_s1_vld) begin
            r_wr_addr <= r_s1_addr;
            r_wr_data <= w_comb_data;
         end
      end
   end

   generate
      for (genvar k = 0; k < LANES; k++) begin : g_lane
         rdm_llr_sat_add u_sat_add (
            .i_rd_llr    (i_ram_rd_data[k*LLR_W +: LLR_W]),
            .i_new_llr   (r_s1_data[k*LLR_W +: LLR_W]),
            .i_overwrite (r_s1_ovr),
            .i_lane_en   (r_s1_lane_en[k]),
            .o_llr       (w_comb_data[k*LLR_W +: LLR_W])
         );
      end
   endgenerate

   assign o_rdm_data_request = w_accepting;
   assign o_ram_rd_en        = w_accept && !w_overwrite;
   assign o_ram_rd_addr      = r_ptr;
   // Gated by reset so an in-flight write is dropped in the reset cycle itself.
   assign o_ram_wr_en        = r_wr_en && i_rx_rstn;
   assign o_ram_wr_addr      = r_wr_addr;
   assign o_ram_wr_data      = r_wr_data;
   assign o_combine_done     = (r_state == ST_DONE);
   assign o_combine_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rdm_harq_combine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_rdm_harq_combine : directed vector table plus hand sequences for
// early completion, ignored restart and mid-run reset
// Rev 1.0
// ============================================================================
module tb_rdm_harq_combine;

   typedef struct packed {
      bit first_tx;
      int ncb;
      int wt;
      int gap;
      int pre;
      int beat;
      bit extra;
      int nw;
      int v_lo;
      int n_lo;
      int v_hi;
      int last_l;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic        first_tx = 1'b0;
   logic [15:0] ncb = 16'd64;
   logic [11:0] wt = 12'd1;
   logic        valid = 1'b0;
   logic [95:0] rdata = '0;
   logic        comp = 1'b0;
   logic        req, rd_en, wr_en, done, err;
   logic [11:0] rd_addr, wr_addr;
   logic [95:0] wr_data;
   logic [95:0] ram_q = '0;

   logic [95:0] mem [0:4095];
   int          rd_cnt = 0;
   int          wr_addrs[$];

   int checks = 0;
   int failures = 0;
   vec_t vecs[10];

   always #5 clk = ~clk;

   rdm_harq_combine dut (
      .i_core_clk         (clk),
      .i_rx_rstn          (rstn),
      .i_combine_start    (start),
      .i_first_tx         (first_tx),
      .i_ncb_size         (ncb),
      .i_word_total       (wt),
      .o_rdm_data_request (req),
      .i_rdm_data_valid   (valid),
      .i_rdm_data         (rdata),
      .i_rdm_data_comp    (comp),
      .o_ram_rd_addr      (rd_addr),
      .o_ram_rd_en        (rd_en),
      .i_ram_rd_data      (ram_q),
      .o_ram_wr_en        (wr_en),
      .o_ram_wr_addr      (wr_addr),
      .o_ram_wr_data      (wr_data),
      .o_combine_done     (done),
      .o_combine_err      (err)
   );

   // Combine RAM model: synchronous read, one-cycle latency.
   always @(posedge clk) begin
      if (rd_en) begin
         ram_q <= mem[rd_addr];
         rd_cnt = rd_cnt + 1;
      end
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
         wr_addrs.push_back(int'(wr_addr));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   function automatic logic [95:0] splat(input int v, input int nl);
      logic [95:0] r;
      logic [5:0]  l;
      r = '0;
      l = v[5:0];
      for (int k = 0; k < 16; k++) begin
         if (k < nl) r[6*k +: 6] = l;
      end
      return r;
   endfunction

   task automatic preload(input int v);
      for (int a = 0; a < 16; a++) mem[a] = splat(v, 16);
      wr_addrs.delete();
      rd_cnt = 0;
   endtask

   task automatic wait_done(input bit hold_valid, output int n);
      n = 1;
      valid = hold_valid;
      while (done !== 1'b1 && n < 20) begin
         tick();
         n++;
         if (n >= 3) valid = 1'b0;
      end
      valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int  nwc, n, nrd;
      bit  req_ok, addr_ok;
      preload(v.pre);
      nwc = (v.ncb + 15) / 16;
      first_tx = v.first_tx;
      ncb = 16'(v.ncb);
      wt = 12'(v.wt);
      start = 1'b1;
      tick();
      start = 1'b0;
      first_tx = !v.first_tx;
      ncb = 16'd48;
      wt = 12'd1;
      req_ok = 1'b1;
      for (int b = 0; b < v.wt; b++) begin
         for (int g = 0; g < v.gap; g++) begin
            valid = 1'b0;
            tick();
            if (req !== 1'b1) req_ok = 1'b0;
         end
         valid = 1'b1;
         rdata = splat(v.beat, 16);
         tick();
         if (b < v.wt - 1 && req !== 1'b1) req_ok = 1'b0;
      end
      wait_done(v.extra, n);
      check($sformatf("v%0d_done_latency", idx), n, 3);
      check($sformatf("v%0d_req_held", idx), req_ok, 1);
      check($sformatf("v%0d_err", idx), err, 0);
      tick();
      check($sformatf("v%0d_done_pulse", idx), {done, req}, 0);
      addr_ok = 1'b1;
      for (int b = 0; b < wr_addrs.size() && b < v.wt; b++) begin
         if (wr_addrs[b] != b % nwc) addr_ok = 1'b0;
      end
      check($sformatf("v%0d_wr_count", idx), wr_addrs.size(), v.wt);
      check($sformatf("v%0d_wr_addr_seq", idx), addr_ok, 1);
      nrd = v.first_tx ? ((v.wt > nwc) ? v.wt - nwc : 0) : v.wt;
      check($sformatf("v%0d_rd_count", idx), rd_cnt, nrd);
      for (int w = 0; w < v.nw; w++) begin
         check($sformatf("v%0d_word%0d", idx, w), mem[w],
               splat((w < v.n_lo) ? v.v_lo : v.v_hi, (w == v.nw - 1) ? v.last_l : 16));
      end
      check($sformatf("v%0d_untouched", idx), mem[v.nw], splat(v.pre, 16));
   endtask

   initial begin
      int n;
      int ws;
      for (int a = 0; a < 4096; a++) mem[a] = '0;

      rstn = 1'b0;
      repeat (3) tick();
      check("reset_ctrl", {req, rd_en, wr_en, done, err}, 0);
      check("reset_addr", {rd_addr, wr_addr}, 0);
      check("reset_wdata", wr_data, 0);
      rstn = 1'b1;
      tick();

      //           ftx   ncb  wt gap  pre beat extra nw v_lo n_lo v_hi last_l
      vecs[0] = '{1'b1,  64,  4,  0,   9,   5, 1'b1, 4,   5,   4,   0, 16};
      vecs[1] = '{1'b1,  48,  5,  0,   9,  20, 1'b0, 3,  31,   2,  20, 16};
      vecs[2] = '{1'b0,  64,  2,  0, -25, -10, 1'b0, 2, -31,   2,   0, 16};
      vecs[3] = '{1'b0,  64,  2,  0,   3,  -7, 1'b0, 2,  -4,   2,   0, 16};
      vecs[4] = '{1'b1,  50,  4,  0,   9,   7, 1'b0, 4,   7,   4,   0,  2};
      vecs[5] = '{1'b1, 128,  6,  2,   9, -12, 1'b1, 6, -12,   6,   0, 16};
      vecs[6] = '{1'b1,  64,  1,  0,   9, -32, 1'b0, 1, -31,   1,   0, 16};
      vecs[7] = '{1'b0,  64,  3,  1,  30,   1, 1'b0, 3,  31,   3,   0, 16};
      vecs[8] = '{1'b0,  50,  5,  0,  10,   4, 1'b0, 4,  18,   1,  14,  2};
      vecs[9] = '{1'b0,  64,  2,  0, -20,  25, 1'b0, 2,   5,   2,   0, 16};
      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // Upstream completion after 2 of 4 beats.
      preload(9);
      first_tx = 1'b1; ncb = 16'd64; wt = 12'd4; start = 1'b1;
      tick();
      start = 1'b0;
      rdata = splat(3, 16);
      valid = 1'b1; tick();
      valid = 1'b1; tick();
      valid = 1'b0; comp = 1'b1; tick();
      comp = 1'b0;
      wait_done(1'b0, n);
      check("comp_done_latency", n, 3);
      check("comp_err_set", err, 1);
      check("comp_wr_count", wr_addrs.size(), 2);
      tick();
      check("comp_err_sticky", err, 1);
      wt = 12'd1; start = 1'b1;
      tick();
      start = 1'b0;
      check("comp_err_cleared", err, 0);
      valid = 1'b1; tick();
      wait_done(1'b0, n);
      check("comp_restart_done", n, 3);
      tick();

      // Start pulse while running is ignored.
      preload(9);
      first_tx = 1'b1; ncb = 16'd64; wt = 12'd3; start = 1'b1;
      tick();
      start = 1'b0;
      rdata = splat(2, 16);
      valid = 1'b1; tick();
      start = 1'b1; wt = 12'd1; ncb = 16'd48; first_tx = 1'b0;
      tick();
      start = 1'b0;
      tick();
      wait_done(1'b0, n);
      check("restart_done_latency", n, 3);
      check("restart_wr_count", wr_addrs.size(), 3);
      check("restart_rd_count", rd_cnt, 0);
      check("restart_word2", mem[2], splat(2, 16));
      tick();

      // Reset during RUN drops the in-flight writes.
      preload(9);
      first_tx = 1'b1; ncb = 16'd128; wt = 12'd8; start = 1'b1;
      tick();
      start = 1'b0;
      rdata = splat(6, 16);
      valid = 1'b1;
      repeat (3) tick();
      valid = 1'b0;
      rstn = 1'b0;
      ws = wr_addrs.size();
      check("rst_pre_wr", ws, 1);
      tick();
      check("rst_outs_ctrl", {req, rd_en, wr_en, done, err}, 0);
      check("rst_outs_data", {rd_addr, wr_addr, wr_data}, 0);
      tick();
      rstn = 1'b1;
      repeat (3) tick();
      check("rst_no_wr", wr_addrs.size(), ws);
      check("rst_idle", {req, done}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
